// File: rtl/vga_fill_ctrl.sv
// Write-side controller for the VGA frame buffer: CPU pass-through with absolute
// priority, plus a rectangle-fill engine issuing one pixel write per free cycle.
module vga_fill_ctrl #(
  parameter int H_PIXELS = 160,
  parameter int V_PIXELS = 120
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_cpuAddr,
  input  logic [31:0] i_cpuData,
  input  logic        i_cpuWe,
  input  logic        i_start,
  input  logic [7:0]  i_x0,
  input  logic [7:0]  i_x1,
  input  logic [7:0]  i_y0,
  input  logic [7:0]  i_y1,
  input  logic [2:0]  i_planeMask,
  input  logic [31:0] i_fillData,
  input  logic        i_abort,
  output logic [31:0] o_pxlAddr,
  output logic [31:0] o_pxlData,
  output logic        o_pxlWe,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  localparam logic [7:0] X_MAX = 8'(H_PIXELS - 1);
  localparam logic [7:0] Y_MAX = 8'(V_PIXELS - 1);

  state_t      state_q;
  logic [7:0]  x0_q, x1_q, y0_q, y1_q;
  logic [7:0]  x_q, y_q;
  logic [1:0]  plane_q;
  logic [2:0]  mask_q;
  logic [31:0] fill_q;

  logic [7:0]  x1_clamp, y1_clamp;
  logic [2:0]  start_pl, next_pl;
  logic        empty_cmd, last_px;

  // Lowest set mask bit at or above 'from'; bit 2 of the result flags "found".
  function automatic logic [2:0] find_plane(input logic [2:0] mask, input logic [1:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (2'(i) >= from)) begin
        r = {1'b1, 2'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Command clamping/emptiness and end-of-scan detection.
  always_comb begin
    x1_clamp  = (i_x1 > X_MAX) ? X_MAX : i_x1;
    y1_clamp  = (i_y1 > Y_MAX) ? Y_MAX : i_y1;
    start_pl  = find_plane(i_planeMask, 2'd0);
    empty_cmd = (i_x0 > x1_clamp) || (i_y0 > y1_clamp) || !start_pl[2];
    next_pl   = find_plane(mask_q, plane_q + 2'd1);
    last_px   = (x_q == x1_q) && (y_q == y1_q) && !next_pl[2];
  end

  assign o_busy = (state_q == FILL);

  // Fill FSM, counters and registered write port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      x0_q      <= 8'd0;
      x1_q      <= 8'd0;
      y0_q      <= 8'd0;
      y1_q      <= 8'd0;
      x_q       <= 8'd0;
      y_q       <= 8'd0;
      plane_q   <= 2'd0;
      mask_q    <= 3'd0;
      fill_q    <= 32'd0;
      o_pxlAddr <= 32'd0;
      o_pxlData <= 32'd0;
      o_pxlWe   <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_pxlWe <= 1'b0;
      o_done  <= 1'b0;
      if (i_cpuWe) begin
        o_pxlAddr <= i_cpuAddr;
        o_pxlData <= i_cpuData;
        o_pxlWe   <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (i_start) begin
            x0_q   <= i_x0;
            x1_q   <= x1_clamp;
            y0_q   <= i_y0;
            y1_q   <= y1_clamp;
            mask_q <= i_planeMask;
            fill_q <= i_fillData;
            if (empty_cmd) begin
              o_done <= 1'b1;
            end else begin
              state_q <= FILL;
              x_q     <= i_x0;
              y_q     <= i_y0;
              plane_q <= start_pl[1:0];
            end
          end
        end
        FILL: begin
          if (i_abort) begin
            state_q <= IDLE;
          end else if (!i_cpuWe) begin
            o_pxlAddr <= {14'h0, plane_q, y_q, x_q};
            o_pxlData <= fill_q;
            o_pxlWe   <= 1'b1;
            // Compare before incrementing so x=255 / y=255 never wrap.
            if (last_px) begin
              o_done  <= 1'b1;
              state_q <= IDLE;
            end else if (x_q != x1_q) begin
              x_q <= x_q + 8'd1;
            end else begin
              x_q <= x0_q;
              if (y_q != y1_q) begin
                y_q <= y_q + 8'd1;
              end else begin
                y_q     <= y0_q;
                plane_q <= next_pl[1:0];
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Self-checking bench for vga_fill_ctrl: directed test-plan scenarios plus random
// commands, checked every cycle against a queue-based model of the write stream.
module tb_vga_fill_ctrl;
  localparam int H = 160;
  localparam int V = 120;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_cpuAddr, i_cpuData, i_fillData;
  logic        i_cpuWe, i_start, i_abort;
  logic [7:0]  i_x0, i_x1, i_y0, i_y1;
  logic [2:0]  i_planeMask;
  logic [31:0] o_pxlAddr, o_pxlData;
  logic        o_pxlWe, o_busy, o_done;

  always #5 clk = ~clk;

  vga_fill_ctrl #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_cpuAddr(i_cpuAddr), .i_cpuData(i_cpuData),
    .i_cpuWe(i_cpuWe), .i_start(i_start), .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0),
    .i_y1(i_y1), .i_planeMask(i_planeMask), .i_fillData(i_fillData), .i_abort(i_abort),
    .o_pxlAddr(o_pxlAddr), .o_pxlData(o_pxlData), .o_pxlWe(o_pxlWe),
    .o_busy(o_busy), .o_done(o_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: the pending fill pixels as a queue, in scan order.
  logic [31:0] fq[$];
  bit          fill_on;
  logic [31:0] m_addr, m_data, m_fdata;
  int          obs_fill;

  task automatic build_queue();
    int x1c, y1c;
    x1c = (int'(i_x1) > H - 1) ? H - 1 : int'(i_x1);
    y1c = (int'(i_y1) > V - 1) ? V - 1 : int'(i_y1);
    fq.delete();
    m_fdata = i_fillData;
    for (int p = 0; p < 3; p++)
      if (i_planeMask[p])
        for (int y = int'(i_y0); y <= y1c; y++)
          for (int x = int'(i_x0); x <= x1c; x++)
            fq.push_back({14'h0, 2'(p), 8'(y), 8'(x)});
  endtask

  // One clock: advance the model with the inputs seen at the edge, compare, clear pulses.
  task automatic tick();
    bit e_we, e_done, cpu;
    @(posedge clk); #1;
    cpu    = i_cpuWe;
    e_we   = 1'b0;
    e_done = 1'b0;
    if (cpu) begin
      e_we   = 1'b1;
      m_addr = i_cpuAddr;
      m_data = i_cpuData;
    end
    if (!fill_on) begin
      if (i_start) begin
        build_queue();
        if (fq.size() == 0) e_done = 1'b1;
        else fill_on = 1'b1;
      end
    end else if (i_abort) begin
      fill_on = 1'b0;
      fq.delete();
    end else if (!cpu) begin
      e_we   = 1'b1;
      m_addr = fq.pop_front();
      m_data = m_fdata;
      if (fq.size() == 0) begin
        e_done  = 1'b1;
        fill_on = 1'b0;
      end
    end
    check_val("we",   32'(o_pxlWe), 32'(e_we));
    check_val("done", 32'(o_done),  32'(e_done));
    check_val("busy", 32'(o_busy),  32'(fill_on));
    check_val("addr", o_pxlAddr, m_addr);
    check_val("data", o_pxlData, m_data);
    if (o_pxlWe && !cpu) obs_fill++;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_cpuWe = 1'b0;
  endtask

  task automatic start_cmd(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] y0,
                           input logic [7:0] y1, input logic [2:0] mask, input logic [31:0] d);
    i_x0 = x0; i_x1 = x1; i_y0 = y0; i_y1 = y1;
    i_planeMask = mask; i_fillData = d;
    i_start = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (fill_on && n < budget) begin
      tick();
      n++;
    end
    check_val("fill_timeout", 32'(fill_on), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_we"},   32'(o_pxlWe), 32'd0);
    check_val({tag, "_addr"}, o_pxlAddr, 32'd0);
    check_val({tag, "_data"}, o_pxlData, 32'd0);
    check_val({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_val({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_cpuAddr = 32'd0; i_cpuData = 32'd0; i_cpuWe = 1'b0;
    i_start = 1'b0; i_abort = 1'b0; i_x0 = 8'd0; i_x1 = 8'd0; i_y0 = 8'd0; i_y1 = 8'd0;
    i_planeMask = 3'd0; i_fillData = 32'd0;
    fill_on = 1'b0; m_addr = 32'd0; m_data = 32'd0; m_fdata = 32'd0; obs_fill = 0;
    #1;
    check_zero_outputs("reset");
    @(posedge clk); #2 i_rst = 1'b0;
    tick();

    // Full red plane.
    obs_fill = 0;
    start_cmd(8'd0, 8'd159, 8'd0, 8'd119, 3'b001, 32'hFF);
    tick();
    check_val("full_first_addr", o_pxlAddr, 32'h0000_0000);
    wait_idle(20000);
    check_val("full_count", 32'(obs_fill), 32'd19200);
    check_val("full_last_addr", o_pxlAddr, 32'h0000_779F);
    tick();
    check_val("full_busy_after", 32'(o_busy), 32'd0);

    // Clamp and mask skip.
    obs_fill = 0;
    start_cmd(8'd150, 8'd200, 8'd118, 8'd130, 3'b101, 32'h1234_5678);
    wait_idle(100);
    check_val("clamp_count", 32'(obs_fill), 32'd40);
    check_val("clamp_last_addr", o_pxlAddr, 32'h0002_779F);

    // CPU priority stalls the fill.
    obs_fill = 0;
    start_cmd(8'd10, 8'd13, 8'd5, 8'd5, 3'b010, 32'hA5A5_A5A5);
    tick();
    i_cpuWe = 1'b1; i_cpuAddr = 32'h0002_0304; i_cpuData = 32'hC0DE_0001;
    tick();
    i_cpuWe = 1'b1; i_cpuAddr = 32'h0002_0304; i_cpuData = 32'hC0DE_0002;
    tick();
    wait_idle(20);
    check_val("cpu_fill_count", 32'(obs_fill), 32'd4);

    // Empty command.
    obs_fill = 0;
    start_cmd(8'd20, 8'd10, 8'd0, 8'd0, 3'b001, 32'h1);
    check_val("empty_done", 32'(o_done), 32'd1);
    tick();
    check_val("empty_done_drop", 32'(o_done), 32'd0);
    start_cmd(8'd0, 8'd3, 8'd0, 8'd0, 3'b000, 32'h1);
    check_val("empty_mask_done", 32'(o_done), 32'd1);
    tick();
    check_val("empty_writes", 32'(obs_fill), 32'd0);

    // Abort, ignored restart during FILL, then a fresh start.
    obs_fill = 0;
    start_cmd(8'd0, 8'd9, 8'd0, 8'd0, 3'b001, 32'h55);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        i_start = 1'b1; i_x0 = 8'd100; i_x1 = 8'd110; i_y0 = 8'd50; i_y1 = 8'd50;
        i_planeMask = 3'b100; i_fillData = 32'hDEAD;
      end
      tick();
    end
    i_abort = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check_val("abort_writes", 32'(obs_fill), 32'd5);
    obs_fill = 0;
    i_abort = 1'b1;
    start_cmd(8'd250, 8'd255, 8'd119, 8'd119, 3'b010, 32'h77);
    wait_idle(50);
    check_val("restart_count", 32'(obs_fill), 32'd0);
    obs_fill = 0;
    start_cmd(8'd159, 8'd159, 8'd0, 8'd2, 3'b110, 32'h99);
    wait_idle(50);
    check_val("single_col_count", 32'(obs_fill), 32'd6);

    // Random commands with random CPU traffic, aborts and ignored starts.
    for (int t = 0; t < 40; t++) begin
      int xa, ya;
      xa = $urandom_range(0, 165);
      ya = $urandom_range(0, 125);
      start_cmd(8'(xa), 8'((xa + $urandom_range(0, 9) > 255) ? 255 : xa + $urandom_range(0, 9)),
                8'(ya), 8'(ya + $urandom_range(0, 3) - ($urandom_range(0, 9) == 0 ? 4 : 0)),
                3'($urandom_range(0, 7)), $urandom);
      for (int c = 0; c < 400 && fill_on; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          i_cpuWe = 1'b1; i_cpuAddr = {14'h0, 18'($urandom)}; i_cpuData = $urandom;
        end
        if ($urandom_range(0, 60) == 0) i_abort = 1'b1;
        if ($urandom_range(0, 9) == 0) begin
          i_start = 1'b1; i_x0 = 8'($urandom); i_x1 = 8'($urandom);
          i_y0 = 8'($urandom); i_y1 = 8'($urandom); i_fillData = $urandom;
        end
        tick();
      end
      wait_idle(10);
      tick();
    end

    // Asynchronous reset mid-fill.
    start_cmd(8'd0, 8'd159, 8'd0, 8'd119, 3'b111, 32'hBEEF);
    for (int i = 0; i < 10; i++) tick();
    @(posedge clk); #3 i_rst = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    fill_on = 1'b0; fq.delete(); m_addr = 32'd0; m_data = 32'd0;
    @(posedge clk); #2 i_rst = 1'b0;
    obs_fill = 0;
    for (int i = 0; i < 20; i++) tick();
    check_val("rst_residual", 32'(obs_fill), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
